// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch front end.
package fetch_pkg;

  // REQ: request outstanding; FULL: queue full, no request;
  // DROP: waiting for the response of a fetch that was squashed.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    FULL = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // One fetched instruction word together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO of fetch entries with push/pop/flush.
// Flush wins over push and pop. Push while full is accepted only together
// with a pop. The head entry is read combinationally from the storage array.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CNT_DEPTH);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !flush && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the PC, drives the ROM
// request port, buffers fetched words in fetch_fifo and hands them to decode.
// Optional macro FETCH_BYPASS_EN: forward a ROM response straight to decode
// when the queue is empty (zero-cycle fetch-to-decode latency).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        RAZ,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        i_req,
  output logic [31:0] i_address,
  input  logic [31:0] i_data_read,
  input  logic        i_data_valid,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   target_q, target_d;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_wdata;
  logic          bypass_take;

  // The address is held in pc_q for the whole life of a request.
  assign i_address  = pc_q;
  assign i_req      = (state_q != FULL);
  assign fifo_wdata = '{pc: pc_q, instr: i_data_read};
  // A redirect turns a same-cycle pop into a no-op.
  assign fifo_pop   = instr_ready && !fifo_empty && !redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = fifo_empty && !redirect && (state_q == REQ) && i_data_valid;
  assign bypass_take = bypass_hit && instr_ready;
  assign instr_valid = !fifo_empty || bypass_hit;
  assign instr       = fifo_empty ? i_data_read : fifo_head.instr;
  assign instr_pc    = fifo_empty ? pc_q : fifo_head.pc;
`else
  assign bypass_take = 1'b0;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (RAZ),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch FSM next state, PC update, squash target and queue controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      REQ: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          if (i_data_valid) begin
            pc_d = redirect_addr;
          end else begin
            // The ROM is still busy with the old address: wait it out.
            target_d = redirect_addr;
            state_d  = DROP;
          end
        end else if (i_data_valid) begin
          fifo_push = !bypass_take;
          pc_d      = pc_q + PC_STEP;
          if ((fifo_full && !fifo_pop) ||
              (fifo_push && !fifo_pop && (fifo_count == CNT_LAST))) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_addr;
          state_d    = REQ;
        end else if (fifo_pop) begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          if (i_data_valid) begin
            pc_d    = redirect_addr;
            state_d = REQ;
          end else begin
            target_d = redirect_addr;
          end
        end else if (i_data_valid) begin
          pc_d    = target_q;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // FSM, PC and saved redirect target registers.
  always_ff @(posedge clk) begin
    if (RAZ) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario tasks plus a ROM model and a scoreboard of
// expected {pc, word} pairs checked as decode accepts them.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        RAZ;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] i_data_read;
  logic        i_data_valid;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  int rom_lat = 1000;
  int rom_cnt = 0;

  logic        mon_en = 1'b0;
  logic [31:0] m_pc   = RESET_PC;
  logic [31:0] m_tgt  = RESET_PC;
  logic        m_drop = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .RAZ           (RAZ),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .i_req         (i_req),
    .i_address     (i_address),
    .i_data_read   (i_data_read),
    .i_data_valid  (i_data_valid),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ROM: answers rom_lat cycles after a request starts; restarts on reset.
  assign i_data_valid = i_req && (rom_cnt >= rom_lat);
  assign i_data_read  = i_data_valid ? rom_word(i_address) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (RAZ || !i_req || i_data_valid) rom_cnt <= 0;
    else rom_cnt <= rom_cnt + 1;
  end

  // Monitor: tracks the expected fetch address and the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (i_address !== m_pc) begin
        failures++;
        $display("FAIL addr_track: i_address=%h expected %h", i_address, m_pc);
      end
      if (RAZ) begin
        sb.delete();
        m_pc   = RESET_PC;
        m_drop = 1'b0;
      end else if (redirect) begin
        sb.delete();
        if (i_req && !i_data_valid) begin
          m_drop = 1'b1;
          m_tgt  = redirect_addr;
        end else begin
          m_drop = 1'b0;
          m_pc   = redirect_addr;
        end
      end else begin
        if (i_req && i_data_valid) begin
          if (m_drop) begin
            m_drop = 1'b0;
            m_pc   = m_tgt;
          end else begin
            sb.push_back('{pc: i_address, w: rom_word(i_address)});
            m_pc = i_address + 32'd4;
          end
        end
        if (instr_valid && instr_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got pc=%h instr=%h, required no word", instr_pc, instr);
          end else begin
            e = sb.pop_front();
            if (instr_pc !== e.pc || instr !== e.w) begin
              failures++;
              $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                       instr_pc, instr, e.pc, e.w);
            end else begin
              $display("xfer pc=%h instr=%h", instr_pc, instr);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT freshly reset with RAZ low at the start of a cycle.
  task automatic do_reset();
    RAZ      = 1'b1;
    redirect = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    RAZ = 1'b0;
  endtask

  task automatic drain();
    redirect    = 1'b0;
    rom_lat     = 1000;
    instr_ready = 1'b1;
    repeat (DEPTH + 4) tick();
  endtask

  task automatic test_reset();
    rom_lat = 1000; instr_ready = 1'b0; redirect_addr = 32'h0;
    do_reset();
    @(negedge clk);
    checks++; if (i_req !== 1'b1) begin failures++; $display("FAIL reset_i_req: got %b required 1", i_req); end
    checks++; if (i_address !== RESET_PC) begin failures++; $display("FAIL reset_addr: got %h required %h", i_address, RESET_PC); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic        has;
    rom_lat = 0; instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (i_address !== 32'(4 * k)) begin failures++; $display("FAIL stream_addr: got %h required %h", i_address, 32'(4 * k)); end
`ifdef FETCH_BYPASS_EN
      exp_pc = 32'(4 * k); has = 1'b1;
`else
      exp_pc = 32'(4 * (k - 1)); has = (k >= 1);
`endif
      if (has) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
          failures++;
          $display("FAIL stream_head: got valid=%b pc=%h required valid=1 pc=%h", instr_valid, instr_pc, exp_pc);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    rom_lat = 0; instr_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    @(negedge clk);
    checks++; if (i_req !== 1'b0) begin failures++; $display("FAIL full_i_req: got %b required 0", i_req); end
    checks++; if (i_address !== 32'd16) begin failures++; $display("FAIL full_addr: got %h required 10", i_address); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin failures++; $display("FAIL full_head: got valid=%b pc=%h required 1/0", instr_valid, instr_pc); end
    tick();
    @(negedge clk);
    checks++; if (i_req !== 1'b0) begin failures++; $display("FAIL full_hold: got i_req=%b required 0", i_req); end
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    checks++; if (i_req !== 1'b1 || i_address !== 32'd16) begin failures++; $display("FAIL full_resume: got i_req=%b addr=%h required 1/10", i_req, i_address); end
    checks++; if (instr_pc !== 32'd4) begin failures++; $display("FAIL full_head2: got %h required 4", instr_pc); end
    tick();
    @(negedge clk);
    checks++; if (i_req !== 1'b0) begin failures++; $display("FAIL full_refill: got i_req=%b required 0", i_req); end
    drain();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL full_drain: got valid=%b required 0", instr_valid); end
  endtask

  task automatic test_drop();
    int n;
    rom_lat = 3; instr_ready = 1'b1; redirect_addr = 32'h0;
    do_reset();
    repeat (4) tick();
    @(negedge clk);
    checks++; if (i_address !== 32'd4) begin failures++; $display("FAIL drop_pre: got %h required 4", i_address); end
    tick();
    redirect = 1'b1; redirect_addr = 32'h100;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (i_req !== 1'b1 || i_address !== 32'd4 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL drop_hold: got i_req=%b addr=%h valid=%b required 1/4/0", i_req, i_address, instr_valid);
    end
    n = 0;
    while (!i_data_valid && n < 10) begin
      tick(); @(negedge clk); n++;
      checks++; if (i_address !== 32'd4) begin failures++; $display("FAIL drop_wait_addr: got %h required 4", i_address); end
    end
    checks++; if (n >= 10) begin failures++; $display("FAIL drop_timeout: got no ROM response, required one"); end
    tick();
    @(negedge clk);
    checks++; if (i_address !== 32'h100) begin failures++; $display("FAIL drop_target: got %h required 100", i_address); end
    n = 0;
    while (!instr_valid && n < 10) begin tick(); @(negedge clk); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
      failures++; $display("FAIL drop_first: got valid=%b pc=%h required 1/100", instr_valid, instr_pc);
    end
    drain();
  endtask

  task automatic test_redirect_valid();
    logic exp_v;
    rom_lat = 0; instr_ready = 1'b0;
    do_reset();
    repeat (2) tick();
    redirect = 1'b1; redirect_addr = 32'h40;
    @(negedge clk);
    checks++; if (i_address !== 32'd8) begin failures++; $display("FAIL rv_pre: got %h required 8", i_address); end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    exp_v = 1'b0;
`ifdef FETCH_BYPASS_EN
    exp_v = i_data_valid;
`endif
    checks++; if (i_address !== 32'h40 || instr_valid !== exp_v) begin
      failures++; $display("FAIL rv_after: got addr=%h valid=%b required 40/%b", i_address, instr_valid, exp_v);
    end
    instr_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
      failures++; $display("FAIL rv_first: got valid=%b pc=%h required 1/40", instr_valid, instr_pc);
    end
    drain();
  endtask

  task automatic test_redirect_full();
    logic exp_v;
    rom_lat = 0; instr_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h200;
    @(negedge clk);
    checks++; if (i_req !== 1'b0) begin failures++; $display("FAIL rf_pre: got i_req=%b required 0", i_req); end
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    exp_v = 1'b0;
`ifdef FETCH_BYPASS_EN
    exp_v = i_data_valid;
`endif
    checks++; if (i_req !== 1'b1 || i_address !== 32'h200 || instr_valid !== exp_v) begin
      failures++; $display("FAIL rf_after: got i_req=%b addr=%h valid=%b required 1/200/%b", i_req, i_address, instr_valid, exp_v);
    end
    tick();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      failures++; $display("FAIL rf_first: got valid=%b pc=%h required 1/200", instr_valid, instr_pc);
    end
    drain();
  endtask

  task automatic test_reset_midwait();
    int n;
    rom_lat = 3; instr_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    RAZ = 1'b1;
    tick();
    RAZ = 1'b0;
    @(negedge clk);
    checks++; if (i_address !== RESET_PC || instr_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid: got addr=%h valid=%b required %h/0", i_address, instr_valid, RESET_PC);
    end
    n = 0;
    while (!instr_valid && n < 10) begin tick(); @(negedge clk); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
      failures++; $display("FAIL rst_first: got valid=%b pc=%h required 1/%h", instr_valid, instr_pc, RESET_PC);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    rom_lat = 0; instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      rom_lat     = int'($urandom_range(0, 2));
      redirect    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) redirect_addr = 32'hFFFF_FFF8;
      else redirect_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      tick();
    end
    drain();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid: got %b required 0", instr_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb: got %0d words left required 0", sb.size()); end
  endtask

  initial begin
    RAZ = 1'b1; redirect = 1'b0; redirect_addr = 32'h0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_drop();
    test_redirect_valid();
    test_redirect_full();
    test_reset_midwait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
